tb6502_bus_sequencer: RTL and testbench

- Parametrised successor to the 6502 bench clock/interrupt control. Ping-pongs gated CPU and SRAM clock enables, with programmable SRAM wait states and halt.
- Generates periodic, software-acknowledged IRQ and pulsed NMI stimulus, counted in CPU cycles.
- Sits in the 6502 testbench, driving clock_gate_module enables and the cpu6502 irq_n/nmi_n pins.

---
 rtl/tb6502_bus_sequencer_pkg.sv | 27 ++
 rtl/tb6502_bus_sequencer_if.sv | 34 +++
 rtl/tb6502_bus_sequencer_periodic_event.sv | 42 ++++
 rtl/tb6502_bus_sequencer.sv | 137 +++++++++++++
 tb/tb_tb6502_bus_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tb6502_bus_sequencer_pkg.sv
// Shared types for the 6502 bench bus sequencer: phase encoding, event config
// record and default NMI pulse length.
package tb6502_pkg;

    typedef enum logic [1:0] {
        PH_CPU  = 2'd0,
        PH_MEM  = 2'd1,
        PH_WAIT = 2'd2,
        PH_HALT = 2'd3
    } t_phase;

    localparam int NMI_PULSE_DEFAULT = 2;

    // Periods are carried at a fixed maximum width so one record type serves any
    // PERIOD_WIDTH up to this value; unused upper bits are simply zero.
    localparam int PERIOD_FIELD_WIDTH = 32;

    typedef struct packed {
        logic                          enable;
        logic [PERIOD_FIELD_WIDTH-1:0] period;
    } t_tb6502_irq_cfg;

    function automatic logic is_cpu_tick(input t_phase ph);
        return ph == PH_CPU;
    endfunction

endpackage

// File: rtl/tb6502_bus_sequencer_if.sv
// Control/status bundle between the bench controller (master) and the bus
// sequencer (slave).
interface tb6502_bus_sequencer_if #(
    parameter int CYCLE_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int WAIT_WIDTH   = 2
);
    logic                    halt;
    logic [WAIT_WIDTH-1:0]   wait_cycles;
    logic                    irq_enable;
    logic [PERIOD_WIDTH-1:0] irq_period;
    logic                    irq_ack;
    logic                    nmi_enable;
    logic [PERIOD_WIDTH-1:0] nmi_period;
    logic                    nmi_trigger;
    logic                    enable_cpu_clk;
    logic                    enable_sram_clk;
    logic [CYCLE_WIDTH-1:0]  cpu_cycles;
    logic                    irq_n;
    logic                    nmi_n;
    logic                    halted;

    modport master (
        output halt, wait_cycles, irq_enable, irq_period, irq_ack,
               nmi_enable, nmi_period, nmi_trigger,
        input  enable_cpu_clk, enable_sram_clk, cpu_cycles, irq_n, nmi_n, halted
    );

    modport slave (
        input  halt, wait_cycles, irq_enable, irq_period, irq_ack,
               nmi_enable, nmi_period, nmi_trigger,
        output enable_cpu_clk, enable_sram_clk, cpu_cycles, irq_n, nmi_n, halted
    );
endinterface

// File: rtl/tb6502_bus_sequencer_periodic_event.sv
// Tick-gated period counter: flags the tick on which the programmed number of
// ticks since the last hit has elapsed.
module tb6502_periodic_event
    import tb6502_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick_i,
    input  t_tb6502_irq_cfg cfg_i,
    output logic            hit_o
);

    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    active;

    // A lowered period below the running count is not special-cased: the
    // counter runs on to its natural wrap before it can match again.
    always_comb begin
        active = cfg_i.enable && (cfg_i.period != '0);
        hit_o  = tick_i && active &&
                 (PERIOD_FIELD_WIDTH'(cnt_q) == cfg_i.period - PERIOD_FIELD_WIDTH'(1));
        cnt_d  = cnt_q;
        if (!active) begin
            cnt_d = '0;
        end else if (hit_o) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = cnt_q + PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tb6502_bus_sequencer.sv
// Ping-pong CPU/SRAM clock-enable sequencer with wait states and halt, plus
// periodic/acknowledged IRQ and pulsed NMI stimulus counted in CPU cycles.
module tb6502_bus_sequencer
    import tb6502_pkg::*;
#(
    parameter int CYCLE_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int WAIT_WIDTH   = 2,
    parameter int NMI_PULSE    = NMI_PULSE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    tb6502_bus_sequencer_if.slave bus
);

    localparam int PULSE_W = $clog2(NMI_PULSE + 1);

    t_phase                 state_q, state_d;
    logic [WAIT_WIDTH-1:0]  wait_q, wait_d;
    logic [CYCLE_WIDTH-1:0] cycles_q;
    logic                   irq_n_q;
    logic                   nmi_n_q;
    logic [PULSE_W-1:0]     nmi_left_q, nmi_left_d;
    logic                   tick;
    logic                   irq_hit;
    logic                   nmi_hit;
    t_tb6502_irq_cfg        irq_cfg;
    t_tb6502_irq_cfg        nmi_cfg;

    assign tick = is_cpu_tick(state_q);

    // halt and wait_cycles are only looked at when a CPU/SRAM pair completes,
    // so a pair is never split.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            PH_CPU: state_d = PH_MEM;
            PH_MEM: begin
                if (bus.wait_cycles != '0) begin
                    state_d = PH_WAIT;
                    wait_d  = bus.wait_cycles;
                end else begin
                    state_d = bus.halt ? PH_HALT : PH_CPU;
                end
            end
            PH_WAIT: begin
                if (wait_q == WAIT_WIDTH'(1)) begin
                    state_d = bus.halt ? PH_HALT : PH_CPU;
                    wait_d  = '0;
                end else begin
                    wait_d  = wait_q - WAIT_WIDTH'(1);
                end
            end
            PH_HALT: begin
                if (!bus.halt) begin
                    state_d = PH_CPU;
                end
            end
            default: state_d = PH_CPU;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= PH_CPU;
            wait_q   <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            if (tick) begin
                cycles_q <= cycles_q + CYCLE_WIDTH'(1);
            end
        end
    end

    always_comb begin
        irq_cfg.enable = bus.irq_enable;
        irq_cfg.period = PERIOD_FIELD_WIDTH'(bus.irq_period);
        nmi_cfg.enable = bus.nmi_enable;
        nmi_cfg.period = PERIOD_FIELD_WIDTH'(bus.nmi_period);
    end

    tb6502_periodic_event #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_irq_event (
        .clk    (clk),
        .rst_n  (reset_n),
        .tick_i (tick),
        .cfg_i  (irq_cfg),
        .hit_o  (irq_hit)
    );

    tb6502_periodic_event #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_nmi_event (
        .clk    (clk),
        .rst_n  (reset_n),
        .tick_i (tick),
        .cfg_i  (nmi_cfg),
        .hit_o  (nmi_hit)
    );

    // nmi_left counts the CPU ticks still to be seen with nmi_n low; a new
    // event is only accepted once it has drained to zero.
    always_comb begin
        nmi_left_d = nmi_left_q;
        if (nmi_left_q == '0) begin
            if (nmi_hit || bus.nmi_trigger) begin
                nmi_left_d = PULSE_W'(NMI_PULSE);
            end
        end else if (tick) begin
            nmi_left_d = nmi_left_q - PULSE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_n_q    <= 1'b1;
            nmi_n_q    <= 1'b1;
            nmi_left_q <= '0;
        end else begin
            if (irq_hit) begin
                irq_n_q <= 1'b0;
            end else if (bus.irq_ack) begin
                irq_n_q <= 1'b1;
            end
            nmi_left_q <= nmi_left_d;
            nmi_n_q    <= (nmi_left_d == '0);
        end
    end

    assign bus.enable_cpu_clk  = (state_q == PH_CPU);
    assign bus.enable_sram_clk = (state_q == PH_MEM);
    assign bus.halted          = (state_q == PH_HALT);
    assign bus.cpu_cycles      = cycles_q;
    assign bus.irq_n           = irq_n_q;
    assign bus.nmi_n           = nmi_n_q;

endmodule

// File: tb/tb_tb6502_bus_sequencer.sv
// Directed bench for tb6502_bus_sequencer: a slot-position model of the bus
// schedule and interrupt rules is compared against the DUT on every cycle.
module tb_tb6502_bus_sequencer;
    import tb6502_pkg::*;

    // Narrow cycle counter so the wrap is reachable in a short run.
    localparam int CW = 8;
    localparam int PW = 16;
    localparam int WW = 2;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tb6502_bus_sequencer_if #(.CYCLE_WIDTH(CW), .PERIOD_WIDTH(PW), .WAIT_WIDTH(WW)) bus ();

    tb6502_bus_sequencer #(
        .CYCLE_WIDTH(CW), .PERIOD_WIDTH(PW), .WAIT_WIDTH(WW), .NMI_PULSE(NP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: position inside the current CPU/SRAM group (0 = CPU slot,
    // 1 = SRAM slot, 2.. = wait slots), halt flag, tick-based counters.
    int        m_pos;
    int        m_w;
    bit        m_halted;
    int        m_cycles;
    logic [PW-1:0] m_ic;
    logic [PW-1:0] m_nc;
    bit        m_pend;
    int        m_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_w = 0; m_halted = 1'b0; m_cycles = 0;
        m_ic = '0; m_nc = '0; m_pend = 1'b0; m_left = 0;
    endtask

    task automatic model_update();
        bit tick, ifire, nfire;
        tick  = !m_halted && (m_pos == 0);
        ifire = 1'b0;
        nfire = 1'b0;
        if (tick) m_cycles = (m_cycles + 1) % (1 << CW);
        if (!bus.irq_enable || bus.irq_period == 0) m_ic = '0;
        else if (tick) begin
            m_ic = m_ic + 1'b1;
            if (m_ic == bus.irq_period) begin m_ic = '0; ifire = 1'b1; end
        end
        if (!bus.nmi_enable || bus.nmi_period == 0) m_nc = '0;
        else if (tick) begin
            m_nc = m_nc + 1'b1;
            if (m_nc == bus.nmi_period) begin m_nc = '0; nfire = 1'b1; end
        end
        if (ifire) m_pend = 1'b1;
        else if (bus.irq_ack) m_pend = 1'b0;
        if (m_left == 0) begin
            if (nfire || bus.nmi_trigger) m_left = NP;
        end else if (tick) m_left--;
        if (m_halted) begin
            if (!bus.halt) begin m_halted = 1'b0; m_pos = 0; end
        end else if (m_pos == 0) begin
            m_pos = 1;
        end else if (m_pos == 1 && bus.wait_cycles != 0) begin
            m_w = int'(bus.wait_cycles);
            m_pos = 2;
        end else if (m_pos == 1 || m_pos == 1 + m_w) begin
            m_pos = 0;
            m_halted = bus.halt;
        end else begin
            m_pos++;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("enable_cpu_clk", bus.enable_cpu_clk, !m_halted && m_pos == 0);
            check("enable_sram_clk", bus.enable_sram_clk, !m_halted && m_pos == 1);
            check("halted", bus.halted, m_halted);
            check("cpu_cycles", bus.cpu_cycles, m_cycles);
            check("irq_n", bus.irq_n, !m_pend);
            check("nmi_n", bus.nmi_n, m_left == 0);
            check("enables_exclusive", bus.enable_cpu_clk && bus.enable_sram_clk, 0);
        end
    end

    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            model_update();
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rst_cpu_en"}, bus.enable_cpu_clk, 1);
        check({tag, "_rst_sram_en"}, bus.enable_sram_clk, 0);
        check({tag, "_rst_cycles"}, bus.cpu_cycles, 0);
        check({tag, "_rst_irq_n"}, bus.irq_n, 1);
        check({tag, "_rst_nmi_n"}, bus.nmi_n, 1);
        check({tag, "_rst_halted"}, bus.halted, 0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic clear_inputs();
        bus.halt = 1'b0; bus.wait_cycles = '0;
        bus.irq_enable = 1'b0; bus.irq_period = '0; bus.irq_ack = 1'b0;
        bus.nmi_enable = 1'b0; bus.nmi_period = '0; bus.nmi_trigger = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] frozen;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("init");
        chk_en  = 1'b1;
        reset_n = 1'b1;

        // Plain ping-pong: one tick every two clocks.
        clocks(20);
        check("pingpong_cycles", bus.cpu_cycles, 10);

        // Two wait states: four-clock groups.
        bus.wait_cycles = 2'd2;
        clocks(40);
        check("wait2_cycles", bus.cpu_cycles, 20);

        // Halt raised in the CPU slot, held five clocks; NMI triggered while halted.
        bus.wait_cycles = 2'd0;
        bus.halt = 1'b1;
        clocks(2);
        check("halt_entered", bus.halted, 1);
        check("halt_cycles", bus.cpu_cycles, 21);
        frozen = bus.cpu_cycles;
        clocks(1);
        bus.nmi_trigger = 1'b1;
        clocks(1);
        bus.nmi_trigger = 1'b0;
        clocks(1);
        check("halt_frozen", bus.cpu_cycles, frozen);
        check("halt_nmi_low", bus.nmi_n, 0);
        bus.halt = 1'b0;
        clocks(1);
        check("halt_release_cpu", bus.enable_cpu_clk, 1);
        clocks(6);
        check("halt_nmi_done", bus.nmi_n, 1);

        // IRQ period 5: ticks fall on odd clocks after reset.
        do_reset("irq");
        bus.irq_enable = 1'b1;
        bus.irq_period = 16'd5;
        clocks(8);
        check("irq_before_5th", bus.irq_n, 1);
        clocks(1);
        check("irq_after_5th", bus.irq_n, 0);
        clocks(3);
        check("irq_held", bus.irq_n, 0);
        bus.irq_ack = 1'b1;
        clocks(1);
        bus.irq_ack = 1'b0;
        check("irq_acked", bus.irq_n, 1);
        clocks(5);
        bus.irq_ack = 1'b1;
        clocks(1);
        bus.irq_ack = 1'b0;
        check("irq_set_beats_ack", bus.irq_n, 0);
        bus.irq_ack = 1'b1;
        clocks(1);
        bus.irq_ack = 1'b0;
        check("irq_acked2", bus.irq_n, 1);
        clocks(9);
        check("irq_third", bus.irq_n, 0);
        bus.irq_enable = 1'b0;
        clocks(4);
        check("irq_disable_keeps", bus.irq_n, 0);
        bus.irq_ack = 1'b1;
        clocks(1);
        bus.irq_ack = 1'b0;
        check("irq_acked3", bus.irq_n, 1);

        // NMI period 4, pulse of two ticks.
        do_reset("nmi");
        bus.nmi_enable = 1'b1;
        bus.nmi_period = 16'd4;
        clocks(6);
        check("nmi_before_4th", bus.nmi_n, 1);
        clocks(1);
        check("nmi_after_4th", bus.nmi_n, 0);
        clocks(3);
        check("nmi_still_low", bus.nmi_n, 0);
        clocks(1);
        check("nmi_pulse_end", bus.nmi_n, 1);
        clocks(4);
        check("nmi_second", bus.nmi_n, 0);
        bus.nmi_trigger = 1'b1;
        clocks(1);
        bus.nmi_trigger = 1'b0;
        clocks(2);
        check("nmi_no_retrigger_low", bus.nmi_n, 0);
        clocks(1);
        check("nmi_no_retrigger_end", bus.nmi_n, 1);
        bus.nmi_enable = 1'b0;
        bus.nmi_trigger = 1'b1;
        clocks(1);
        bus.nmi_trigger = 1'b0;
        check("nmi_trig_low", bus.nmi_n, 0);
        clocks(2);
        check("nmi_trig_hold", bus.nmi_n, 0);
        clocks(1);
        check("nmi_trig_end", bus.nmi_n, 1);

        // Zero periods never fire; cycle counter wraps (500 ticks mod 256).
        do_reset("zero");
        bus.irq_enable = 1'b1;
        bus.nmi_enable = 1'b1;
        bus.irq_period = '0;
        bus.nmi_period = '0;
        clocks(1000);
        check("zero_cycles_wrap", bus.cpu_cycles, 244);
        check("zero_irq_n", bus.irq_n, 1);
        check("zero_nmi_n", bus.nmi_n, 1);

        // Mixed traffic with mid-count period changes and a reset mid-operation.
        do_reset("mix");
        bus.irq_period = 16'd7;
        bus.nmi_period = 16'd5;
        for (int i = 0; i < 600; i++) begin
            bus.wait_cycles = WW'($urandom_range(0, 3));
            bus.halt        = ($urandom_range(0, 7) == 0);
            bus.irq_ack     = ($urandom_range(0, 5) == 0);
            bus.nmi_trigger = ($urandom_range(0, 15) == 0);
            if (i % 97 == 0) bus.irq_period = PW'($urandom_range(1, 9));
            if (i % 61 == 0) bus.nmi_period = PW'($urandom_range(2, 8));
            if (i == 300) begin
                bus.halt = 1'b1;
                clocks(3);
                do_reset("mid");
            end
            clocks(1);
        end
        clear_inputs();
        clocks(4);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
